hps_link_endpoint: RTL and testbench
====================================

Name: hps_link_endpoint

Overview:
- FPGA-side endpoint of the HPS PIO control protocol.
- Receives image words from the HPS data/valid PIO pair and writes them into the input image buffer.
- Starts the CNN on the HPS start command, latches the ten logits on completion, and holds them until the HPS signals retrieval.
- Sits between the hps Qsys system exports and the CNN core/image buffer.

Parameters:
- DATA_W, 32, width of hps_data word and of each logit
- IMG_WORDS, 196, words per image (28x28 pixels, 4 x 8-bit pixels per word)
- ADDR_W, 8, image buffer address width; must satisfy 2**ADDR_W >= IMG_WORDS
- NUM_CLASSES, 10, number of logits

Ports:
- clk  in  1  system clock, same clock as the hps system
- reset  in  1  synchronous, active-high reset
- hps_data_i  in  DATA_W  data word from HPS PIO
- hps_data_valid_i  in  1  HPS valid level; every toggle marks one new word
- hps_start_conv_i  in  1  HPS start level; a rising edge is a start command
- hps_logits_retrieved_i  in  1  HPS ack level; a rising edge is a release command
- hps_state_o  out  8  state export to HPS: [3:0] state code, [7] overrun, [6:4] zero
- img_we_o  out  1  image buffer write strobe
- img_addr_o  out  ADDR_W  image buffer write address
- img_data_o  out  DATA_W  image buffer write data
- conv_start_o  out  1  one-cycle start pulse to CNN core
- conv_done_i  in  1  one-cycle done pulse from CNN core
- core_logits_i  in  NUM_CLASSES*DATA_W  core logits; valid in the conv_done_i cycle; class k at bits [k*DATA_W +: DATA_W]
- logits_o  out  NUM_CLASSES*DATA_W  latched logits to the HPS logit_k PIOs
- debug_hold_cnt_o  out  32  debug counter export

Behaviour:
- Reset values:
  - state IDLE; hps_state_o = 0x00.
  - img_we_o = 0, img_addr_o = 0, img_data_o = 0, conv_start_o = 0.
  - logits_o = 0, debug_hold_cnt_o = 0, overrun = 0.
- Edge registers on reset:
  - The edge registers for valid, start and retrieved load the current input levels, not 0, so reset never creates a spurious event.
  - This applies equally to reset asserted mid-operation; the transfer in progress is abandoned.
- Word event = hps_data_valid_i differs from its registered copy.
- Start and retrieve events = rising edges against their registered copies.
- State codes: IDLE=0x0, LOADING=0x1, LOADED=0x2, RUNNING=0x3, DONE=0x4.
- IDLE / LOADING, on a word event:
  - Next cycle: img_we_o = 1 for exactly 1 cycle, img_data_o = hps_data_i sampled in the event cycle, img_addr_o = word counter.
  - Counter then increments; state becomes LOADING.
  - The write of word IMG_WORDS-1 moves to LOADED and clears the counter to 0. No wrap write occurs.
- LOADED:
  - Start event -> conv_start_o = 1 for 1 cycle (the cycle after the event), then RUNNING.
  - A word event in LOADED is dropped and sets overrun.
  - If a start event and a word event occur in the same cycle, start wins and the word sets overrun.
- Ignored events:
  - Start events in IDLE, LOADING, RUNNING or DONE are ignored; no overrun.
  - Word events in RUNNING or DONE set overrun; no write.
- RUNNING: conv_done_i -> logits_o <= core_logits_i in the same edge, then DONE. conv_done_i in any other state is ignored.
- DONE:
  - logits_o holds stable.
  - Retrieve event -> IDLE; overrun clears; word counter = 0; logits_o keeps its last value until the next latch.
  - Retrieve events in other states are ignored.
- hps_state_o is registered and reflects the state one cycle after each transition.
- Latency: word event to img_we_o = 1 cycle; start event to conv_start_o = 1 cycle; conv_done_i to DONE on hps_state_o = 2 cycles.
- The HPS must not toggle valid faster than once per 2 clk cycles. Faster toggles are protocol violations with undefined data.

Optional Feature:
- Macro: HPS_LINK_DEBUG_HOLD_CNT_EN.
- Defined:
  - debug_hold_cnt_o counts clk cycles spent in RUNNING plus DONE.
  - It clears on each start event and saturates at 0xFFFFFFFF.
  - It holds its value in IDLE so the HPS can read conv-plus-readout time.
- Undefined: debug_hold_cnt_o is tied to 0 and no counter logic is built.

Decomposition:
- Shared package hps_link_pkg:
  - state enum and 4-bit state codes;
  - OVERRUN_BIT = 7;
  - default IMG_WORDS and NUM_CLASSES constants.
- One sub-module, hps_link_edge_det:
  - one instance per input: valid in toggle mode, start and retrieved in rise mode;
  - reset loads the registered copy from the live input.

Test Plan:
- Load 196 words 0x00000000..0x000000C3 via valid toggles every 4 cycles -> 196 single-cycle writes, addr 0..195, data == addr, hps_state_o goes 0x01 then 0x02 after the last write.
- In LOADED, raise start -> conv_start_o exactly one pulse; hps_state_o = 0x03; drive conv_done_i with logit k = 0x100+k -> logits_o matches, hps_state_o = 0x04.
- In DONE, raise retrieved -> hps_state_o = 0x00; logits_o still 0x100+k; a second load begins again at addr 0.
- Extra toggle in LOADED coincident with a start edge -> no write, conv_start_o pulses, hps_state_o = 0x83; cleared to 0x00 after retrieve.
- Assert reset at word 50 with valid held high -> outputs at reset values; releasing reset with no toggle gives no write; the next toggle writes addr 0.
- With HPS_LINK_DEBUG_HOLD_CNT_EN defined, 40 cycles RUNNING plus 10 cycles DONE -> debug_hold_cnt_o = 50 held in IDLE; with the macro undefined it reads 0.

Source files
------------

// File: rtl/hps_link_pkg.sv
// Shared types and constants for the HPS PIO link endpoint.
// Holds the state codes exported to the HPS, the overrun bit position,
// the edge-detector mode type and the default image/class sizes.
package hps_link_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'h0,
    ST_LOADING = 4'h1,
    ST_LOADED  = 4'h2,
    ST_RUNNING = 4'h3,
    ST_DONE    = 4'h4
  } link_state_e;

  typedef enum logic {
    EDGE_TOGGLE = 1'b0,
    EDGE_RISE   = 1'b1
  } edge_mode_e;

  localparam int OVERRUN_BIT     = 7;
  localparam int IMG_WORDS_DEF   = 196;
  localparam int NUM_CLASSES_DEF = 10;

  // Builds the 8-bit state export: code in [3:0], overrun flag, rest zero.
  function automatic logic [7:0] pack_state(input link_state_e st, input logic ovr);
    logic [7:0] r;
    r              = 8'h00;
    r[3:0]         = st;
    r[OVERRUN_BIT] = ovr;
    return r;
  endfunction

endpackage

// File: rtl/hps_link_edge_det.sv
// Event detector for one HPS PIO level.
// EDGE_TOGGLE flags any change of level, EDGE_RISE flags only 0->1.
// Reset loads the live level so leaving reset never fakes an event.
module hps_link_edge_det
  import hps_link_pkg::*;
#(
  parameter edge_mode_e MODE = EDGE_TOGGLE
) (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic event_o
);

  logic prev_d;
  logic prev_q;

  // Next registered copy is simply the current level.
  always_comb begin
    prev_d = level_i;
  end

  // Registered copy of the level; reset samples the live input.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= level_i;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Event decode according to the configured mode.
  always_comb begin
    if (MODE == EDGE_RISE) begin
      event_o = level_i & ~prev_q;
    end else begin
      event_o = level_i ^ prev_q;
    end
  end

endmodule

// File: rtl/hps_link_endpoint.sv
// FPGA-side endpoint of the HPS PIO control protocol: loads image words
// into the image buffer, launches the CNN and holds its logits for the HPS.
// Optional feature macro: HPS_LINK_DEBUG_HOLD_CNT_EN (RUNNING+DONE cycle counter).
module hps_link_endpoint
  import hps_link_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int IMG_WORDS   = IMG_WORDS_DEF,
  parameter int ADDR_W      = 8,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             hps_data_i,
  input  logic                          hps_data_valid_i,
  input  logic                          hps_start_conv_i,
  input  logic                          hps_logits_retrieved_i,
  output logic [7:0]                    hps_state_o,
  output logic                          img_we_o,
  output logic [ADDR_W-1:0]             img_addr_o,
  output logic [DATA_W-1:0]             img_data_o,
  output logic                          conv_start_o,
  input  logic                          conv_done_i,
  input  logic [NUM_CLASSES*DATA_W-1:0] core_logits_i,
  output logic [NUM_CLASSES*DATA_W-1:0] logits_o,
  output logic [31:0]                   debug_hold_cnt_o
);

  localparam int LOGIT_W = NUM_CLASSES * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WORDS - 32'd1);

  logic word_ev;
  logic start_ev;
  logic ret_ev;

  link_state_e         state_d, state_q;
  logic [ADDR_W-1:0]   cnt_d, cnt_q;
  logic                overrun_d, overrun_q;
  logic                img_we_d, img_we_q;
  logic [ADDR_W-1:0]   img_addr_d, img_addr_q;
  logic [DATA_W-1:0]   img_data_d, img_data_q;
  logic                conv_start_d, conv_start_q;
  logic [LOGIT_W-1:0]  logits_d, logits_q;
  logic [7:0]          hps_state_d, hps_state_q;

  hps_link_edge_det #(.MODE(EDGE_TOGGLE)) u_valid_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (hps_data_valid_i),
    .event_o (word_ev)
  );

  hps_link_edge_det #(.MODE(EDGE_RISE)) u_start_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (hps_start_conv_i),
    .event_o (start_ev)
  );

  hps_link_edge_det #(.MODE(EDGE_RISE)) u_ret_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (hps_logits_retrieved_i),
    .event_o (ret_ev)
  );

  // Protocol state machine: next state, buffer write, start pulse, logit latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    overrun_d    = overrun_q;
    img_we_d     = 1'b0;
    img_addr_d   = img_addr_q;
    img_data_d   = img_data_q;
    conv_start_d = 1'b0;
    logits_d     = logits_q;
    case (state_q)
      ST_IDLE, ST_LOADING: begin
        if (word_ev) begin
          img_we_d   = 1'b1;
          img_addr_d = cnt_q;
          img_data_d = hps_data_i;
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = {ADDR_W{1'b0}};
            state_d = ST_LOADED;
          end else begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = ST_LOADING;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOADED: begin
        // Start wins over a coincident word; the word still flags overrun.
        if (start_ev) begin
          conv_start_d = 1'b1;
          state_d      = ST_RUNNING;
        end else begin
          state_d = state_q;
        end
        if (word_ev) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      ST_RUNNING: begin
        if (conv_done_i) begin
          logits_d = core_logits_i;
          state_d  = ST_DONE;
        end else begin
          state_d = state_q;
        end
        if (word_ev) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      ST_DONE: begin
        // Release clears overrun; a word arriving in the same cycle is dropped.
        if (ret_ev) begin
          state_d   = ST_IDLE;
          overrun_d = 1'b0;
          cnt_d     = {ADDR_W{1'b0}};
        end else if (word_ev) begin
          overrun_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    hps_state_d = pack_state(state_q, overrun_q);
  end

  // Protocol registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {ADDR_W{1'b0}};
      overrun_q    <= 1'b0;
      img_we_q     <= 1'b0;
      img_addr_q   <= {ADDR_W{1'b0}};
      img_data_q   <= {DATA_W{1'b0}};
      conv_start_q <= 1'b0;
      logits_q     <= {LOGIT_W{1'b0}};
      hps_state_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      img_we_q     <= img_we_d;
      img_addr_q   <= img_addr_d;
      img_data_q   <= img_data_d;
      conv_start_q <= conv_start_d;
      logits_q     <= logits_d;
      hps_state_q  <= hps_state_d;
    end
  end

  assign hps_state_o  = hps_state_q;
  assign img_we_o     = img_we_q;
  assign img_addr_o   = img_addr_q;
  assign img_data_o   = img_data_q;
  assign conv_start_o = conv_start_q;
  assign logits_o     = logits_q;

`ifdef HPS_LINK_DEBUG_HOLD_CNT_EN
  logic [31:0] dbg_d, dbg_q;

  // Cycle count over RUNNING+DONE, cleared on accepted start, saturating.
  always_comb begin
    if (state_q == ST_LOADED && start_ev) begin
      dbg_d = 32'h0000_0000;
    end else if ((state_q == ST_RUNNING || state_q == ST_DONE) && dbg_q != 32'hFFFF_FFFF) begin
      dbg_d = dbg_q + 32'h0000_0001;
    end else begin
      dbg_d = dbg_q;
    end
  end

  // Debug counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_q <= 32'h0000_0000;
    end else begin
      dbg_q <= dbg_d;
    end
  end

  assign debug_hold_cnt_o = dbg_q;
`else
  assign debug_hold_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_hps_link_endpoint.sv
// Directed-plus-random bench for hps_link_endpoint with a protocol-level model.
module tb_hps_link_endpoint;

  localparam int DW = 32;
  localparam int NC = 10;
  localparam int AW = 8;
  localparam int NW = 196;
  localparam int LW = NC * DW;

  localparam int M_IDLE    = 0;
  localparam int M_LOADING = 1;
  localparam int M_LOADED  = 2;
  localparam int M_RUNNING = 3;
  localparam int M_DONE    = 4;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] hps_data_i;
  logic          hps_data_valid_i;
  logic          hps_start_conv_i;
  logic          hps_logits_retrieved_i;
  logic [7:0]    hps_state_o;
  logic          img_we_o;
  logic [AW-1:0] img_addr_o;
  logic [DW-1:0] img_data_o;
  logic          conv_start_o;
  logic          conv_done_i;
  logic [LW-1:0] core_logits_i;
  logic [LW-1:0] logits_o;
  logic [31:0]   debug_hold_cnt_o;

  hps_link_endpoint dut (
    .clk                    (clk),
    .reset                  (reset),
    .hps_data_i             (hps_data_i),
    .hps_data_valid_i       (hps_data_valid_i),
    .hps_start_conv_i       (hps_start_conv_i),
    .hps_logits_retrieved_i (hps_logits_retrieved_i),
    .hps_state_o            (hps_state_o),
    .img_we_o               (img_we_o),
    .img_addr_o             (img_addr_o),
    .img_data_o             (img_data_o),
    .conv_start_o           (conv_start_o),
    .conv_done_i            (conv_done_i),
    .core_logits_i          (core_logits_i),
    .logits_o               (logits_o),
    .debug_hold_cnt_o       (debug_hold_cnt_o)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Observed buffer writes and start pulses, stamped with their cycle.
  wr_t         act_wr[$];
  wr_t         exp_wr[$];
  logic [31:0] act_st[$];
  logic [31:0] exp_st[$];
  wr_t         mon_w;

  always @(negedge clk) begin
    if (img_we_o === 1'b1) begin
      mon_w.cyc  = cyc;
      mon_w.addr = img_addr_o;
      mon_w.data = img_data_o;
      act_wr.push_back(mon_w);
    end
    if (conv_start_o === 1'b1) act_st.push_back(cyc);
  end

  // Protocol-level reference model.
  int          m_state;
  int          m_cnt;
  logic        m_over;
  logic [LW-1:0] m_logits;
  logic [31:0] m_start_cyc;
  logic [31:0] m_dbg;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input logic [31:0] c);
    while (cyc < c) tick();
  endtask

  function automatic logic [LW-1:0] rand_logits();
    logic [LW-1:0] r;
    for (int k = 0; k < NC; k++) r[k*DW +: DW] = $urandom();
    return r;
  endfunction

  function automatic logic [31:0] exp_dbg();
`ifdef HPS_LINK_DEBUG_HOLD_CNT_EN
    return m_dbg;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_state(input string tag);
    logic [7:0] e;
    e = {m_over, 3'b000, 4'(m_state)};
    check(tag, hps_state_o, e);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_wr_count"}, act_wr.size(), exp_wr.size());
    n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_wr%0d", tag, i), act_wr[i], exp_wr[i]);
    act_wr.delete();
    exp_wr.delete();
  endtask

  task automatic compare_starts(input string tag);
    int n;
    check({tag, "_start_count"}, act_st.size(), exp_st.size());
    n = (act_st.size() < exp_st.size()) ? act_st.size() : exp_st.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_start%0d", tag, i), act_st[i], exp_st[i]);
    act_st.delete();
    exp_st.delete();
  endtask

  // Applies one word event to the model: write in IDLE/LOADING, else overrun.
  task automatic model_word(input logic [DW-1:0] d);
    wr_t w;
    if (m_state == M_IDLE || m_state == M_LOADING) begin
      w.cyc  = cyc + 32'd1;
      w.addr = AW'(m_cnt);
      w.data = d;
      exp_wr.push_back(w);
      m_cnt++;
      if (m_cnt == NW) begin
        m_cnt   = 0;
        m_state = M_LOADED;
      end else begin
        m_state = M_LOADING;
      end
    end else begin
      m_over = 1'b1;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int gap);
    hps_data_i       = d;
    hps_data_valid_i = ~hps_data_valid_i;
    model_word(d);
    repeat (gap) tick();
  endtask

  task automatic start_cmd(input bit with_word, input logic [DW-1:0] d);
    int pre;
    pre = m_state;
    hps_start_conv_i = 1'b1;
    if (with_word) begin
      hps_data_i       = d;
      hps_data_valid_i = ~hps_data_valid_i;
      model_word(d);
    end
    if (pre == M_LOADED) begin
      exp_st.push_back(cyc + 32'd1);
      m_state     = M_RUNNING;
      m_start_cyc = cyc;
      m_dbg       = 32'd0;
    end
    tick();
    hps_start_conv_i = 1'b0;
    tick();
  endtask

  task automatic done_cmd(input logic [LW-1:0] lg);
    conv_done_i   = 1'b1;
    core_logits_i = lg;
    if (m_state == M_RUNNING) begin
      m_logits = lg;
      m_state  = M_DONE;
    end
    tick();
    conv_done_i   = 1'b0;
    core_logits_i = rand_logits();
    tick();
  endtask

  task automatic retrieve_cmd();
    hps_logits_retrieved_i = 1'b1;
    if (m_state == M_DONE) begin
      m_state = M_IDLE;
      m_over  = 1'b0;
      m_cnt   = 0;
      m_dbg   = cyc - m_start_cyc;
    end
    tick();
    hps_logits_retrieved_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    m_cnt    = 0;
    m_over   = 1'b0;
    m_logits = '0;
    m_dbg    = 32'd0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, hps_state_o, 8'h00);
    check({tag, "_we"}, img_we_o, 1'b0);
    check({tag, "_addr"}, img_addr_o, 8'h00);
    check({tag, "_data"}, img_data_o, 32'h0);
    check({tag, "_start"}, conv_start_o, 1'b0);
    check({tag, "_logits"}, logits_o, '0);
    check({tag, "_dbg"}, debug_hold_cnt_o, 32'h0);
  endtask

  initial begin
    logic [LW-1:0] lg;
    int i;

    reset                  = 1'b1;
    hps_data_i             = 32'h0;
    hps_data_valid_i       = 1'b0;
    hps_start_conv_i       = 1'b0;
    hps_logits_retrieved_i = 1'b0;
    conv_done_i            = 1'b0;
    core_logits_i          = '0;
    m_start_cyc            = 32'd0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tick();
    check_reset_values("por");

    // Commands in IDLE are ignored.
    start_cmd(1'b0, 32'h0);
    done_cmd(rand_logits());
    retrieve_cmd();
    check_state("idle_ignore_state");
    check("idle_ignore_logits", logits_o, m_logits);
    compare_starts("idle_ignore");

    // Full load with data equal to address, one toggle every 4 cycles.
    for (int w = 0; w < NW; w++) begin
      send_word(32'(w), 4);
      if (w == 0) check_state("load1_first_state");
    end
    check_state("load1_loaded_state");
    compare_writes("load1");

    // Run: 40 cycles RUNNING, 10 cycles DONE.
    start_cmd(1'b0, 32'h0);
    wait_until(m_start_cyc + 32'd3);
    check_state("run1_running_state");
    compare_starts("run1");
    for (int k = 0; k < NC; k++) lg[k*DW +: DW] = 32'h100 + 32'(k);
    wait_until(m_start_cyc + 32'd40);
    done_cmd(lg);
    check_state("run1_done_state");
    check("run1_logits", logits_o, m_logits);
    wait_until(m_start_cyc + 32'd50);
    retrieve_cmd();
    check_state("run1_idle_state");
    check("run1_logits_held", logits_o, lg);
    check("run1_dbg", debug_hold_cnt_o, exp_dbg());
    repeat (5) tick();
    check("run1_dbg_hold", debug_hold_cnt_o, exp_dbg());

    // Second load with random data and spacing, then start with a coincident word.
    for (int w = 0; w < NW; w++) send_word($urandom(), $urandom_range(5, 2));
    check_state("load2_loaded_state");
    compare_writes("load2");
    start_cmd(1'b1, $urandom());
    tick();
    check_state("run2_overrun_state");
    compare_starts("run2");
    send_word($urandom(), 3);
    repeat ($urandom_range(20, 1)) tick();
    done_cmd(rand_logits());
    check_state("run2_done_state");
    check("run2_logits", logits_o, m_logits);
    send_word($urandom(), 3);
    start_cmd(1'b0, 32'h0);
    check_state("run2_done_ignore_state");
    repeat ($urandom_range(10, 1)) tick();
    retrieve_cmd();
    check_state("run2_idle_state");
    check("run2_logits_held", logits_o, m_logits);
    check("run2_dbg", debug_hold_cnt_o, exp_dbg());
    compare_writes("run2");
    compare_starts("run2_tail");

    // Reset in the middle of a load with valid held high.
    i = 0;
    while (i < 50 || hps_data_valid_i == 1'b0) begin
      send_word($urandom(), $urandom_range(4, 2));
      i++;
    end
    check_state("load3_state");
    compare_writes("load3");
    reset = 1'b1;
    tick();
    check_reset_values("midrst");
    tick();
    reset = 1'b0;
    model_reset();
    repeat (6) tick();
    check_reset_values("midrst_release");
    compare_writes("midrst_nowrite");
    send_word(32'hA5A5_0001, 3);
    compare_writes("midrst_restart");
    check_state("midrst_restart_state");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
